// File: rtl/aes_tbox_pkg.sv
// Shared AES T-box definitions: mode codes, GF(2^8) helpers, lane mapping.
// Inverse-table words are built only when TBOX_INV_EN is defined.
package aes_tbox_pkg;

  typedef enum logic [1:0] {
    MODE_ENC       = 2'd0,
    MODE_FINAL     = 2'd1,
    MODE_DEC       = 2'd2,
    MODE_DEC_FINAL = 2'd3
  } mode_e;

  localparam logic [7:0] AES_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [1:0] lane_table(input int k, input int base);
    return 2'((k + base) % 4);
  endfunction

  function automatic logic [31:0] rotr_bytes(input logic [31:0] w,
                                             input logic [1:0]  t);
    logic [31:0] r;
    unique case (t)
      2'd0:    r = w;
      2'd1:    r = {w[7:0], w[31:8]};
      2'd2:    r = {w[15:0], w[31:16]};
      default: r = {w[23:0], w[31:24]};
    endcase
    return r;
  endfunction

  // Table-0 word; other tables are byte rotations of it.
  function automatic logic [31:0] te0_word(input logic [7:0] s,
                                           input logic [1:0] mode);
    logic [7:0]  x2;
    logic [7:0]  x3;
`ifdef TBOX_INV_EN
    logic [7:0]  x4;
    logic [7:0]  x8;
`endif
    logic [31:0] w;
    x2 = xtime(s);
    x3 = x2 ^ s;
`ifdef TBOX_INV_EN
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (mode)
      MODE_ENC: w = {x2, s, s, x3};
      MODE_DEC: w = {x8 ^ x4 ^ x2, x8 ^ s, x8 ^ x4 ^ s, x8 ^ x2 ^ s};
      default:  w = {s, 24'h000000};
    endcase
`else
    if (mode == MODE_FINAL || mode == MODE_DEC_FINAL)
      w = {s, 24'h000000};
    else
      w = {x2, s, s, x3};
`endif
    return w;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup, forward table always present.
// The inverse table and its select input exist only with TBOX_INV_EN.
module aes_sbox (
  input  logic [7:0] in_byte,
`ifdef TBOX_INV_EN
  input  logic       inv,
`endif
  output logic [7:0] out_byte
);

  // Literal lists entry 0 first, so entry x lives at index ~x.
  localparam logic [255:0][7:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef TBOX_INV_EN
  localparam logic [255:0][7:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign out_byte = inv ? INV[~in_byte] : FWD[~in_byte];
`else
  assign out_byte = FWD[~in_byte];
`endif

endmodule

// File: rtl/tbox_lookup_pipe.sv
// Two-stage AES T-box lookup with valid/ready backpressure.
// Define TBOX_INV_EN to add decryption modes 2 and 3.
module tbox_lookup_pipe
  import aes_tbox_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int LANE_BASE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*LANES-1:0]  in_data,
  input  logic [1:0]          in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*LANES-1:0] out_data,
  output logic [1:0]          out_mode
);

  logic                   s1_adv;
  logic                   s2_adv;
  logic [LANES-1:0][7:0]  sbox_s;
  logic [LANES-1:0][31:0] lane_word;

  logic                   s1_valid_q, s1_valid_d;
  logic [1:0]             s1_mode_q, s1_mode_d;
  logic [LANES-1:0][7:0]  s1_s_q, s1_s_d;

  logic                   s2_valid_q, s2_valid_d;
  logic [1:0]             s2_mode_q, s2_mode_d;
  logic [LANES-1:0][31:0] s2_word_q, s2_word_d;

  for (genvar k = 0; k < LANES; k++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (in_data[8*k +: 8]),
`ifdef TBOX_INV_EN
      .inv      (in_mode[1]),
`endif
      .out_byte (sbox_s[k])
    );
  end

  always_comb begin
    lane_word = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_word[k] = rotr_bytes(te0_word(s1_s_q[k], s1_mode_q),
                                lane_table(k, LANE_BASE));
    end
  end

  // Each stage advances when it is empty or its successor moves.
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_s_d     = s1_s_q;
    s2_valid_d = s2_valid_q;
    s2_mode_d  = s2_mode_q;
    s2_word_d  = s2_word_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mode_d = in_mode;
        s1_s_d    = sbox_s;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_mode_d = s1_mode_q;
        s2_word_d = lane_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 2'd0;
      s1_s_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_mode_q  <= 2'd0;
      s2_word_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_s_q     <= s1_s_d;
      s2_valid_q <= s2_valid_d;
      s2_mode_q  <= s2_mode_d;
      s2_word_q  <= s2_word_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_word_q;
  assign out_mode  = s2_mode_q;

endmodule
